// File: rtl/sad_best_match.sv
// Purpose: scan the SAD result memory for its minimum value, that value's address, and the count of entries below a threshold.
// Latency: two cycles per entry. Done pulses in the cycle after edge 2*DEPTH, counting the Go edge as edge 0.
// Backpressure: none. Go is only sampled in IDLE, and a Go that arrives during a scan is dropped, not queued.
module sad_best_match #(
  parameter int C_WIDTH = 7,
  parameter int DEPTH   = 128,
  parameter int S_WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [S_WIDTH-1:0] Thresh,
  output logic [C_WIDTH-1:0] C_Addr,
  output logic               C_RW,
  output logic               C_En,
  input  logic [S_WIDTH-1:0] C_Data,
  output logic               Busy,
  output logic               Done,
  output logic [S_WIDTH-1:0] Min_SAD,
  output logic [C_WIDTH-1:0] Min_Addr,
  output logic [C_WIDTH:0]   Match_Cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    FIN     = 2'd3
  } state_t;

  // Index of the last entry scanned. The scan stops here, so k never wraps.
  localparam logic [C_WIDTH-1:0] K_LAST = C_WIDTH'(DEPTH - 1);

  state_t             state;
  logic [C_WIDTH-1:0] k;
  logic [S_WIDTH-1:0] thresh_q;

  // Entry 0 always seeds the minimum.
  // After that a strict compare keeps the lowest address among equal minima.
  logic take_min;
  logic is_match;
  logic is_last;

  assign take_min = (k == '0) || (C_Data < Min_SAD);
  assign is_match = (C_Data < thresh_q);
  assign is_last  = (k == K_LAST);

  // Scan sequencer. Every output is registered here; Rst overrides everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      k         <= '0;
      thresh_q  <= '0;
      C_Addr    <= '0;
      C_RW      <= 1'b0;
      C_En      <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Min_SAD   <= '0;
      Min_Addr  <= '0;
      Match_Cnt <= '0;
    end else begin
      C_RW <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Go) begin
            // Results from the previous scan stay visible until entry 0 overwrites them.
            // Only the match count is cleared here.
            thresh_q  <= Thresh;
            Match_Cnt <= '0;
            k         <= '0;
            C_En      <= 1'b1;
            C_Addr    <= '0;
            Busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The read was launched on the edge that entered this state.
          // Drop the enable and wait for the data.
          C_En   <= 1'b0;
          C_Addr <= '0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (take_min) begin
            Min_SAD  <= C_Data;
            Min_Addr <= k;
          end
          if (is_match) begin
            Match_Cnt <= Match_Cnt + 1'b1;
          end
          if (is_last) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            k      <= k + 1'b1;
            C_Addr <= k + 1'b1;
            C_En   <= 1'b1;
            state  <= ISSUE;
          end
        end
        FIN: begin
          // Done is high in this cycle. A Go seen here is ignored.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_best_match.sv
// Bench for sad_best_match: checks reset, data patterns, Go while busy, reset mid-scan and back-to-back scans.
// A scoreboard queue holds expected results from a reference model. Each entry is pushed at Go and popped at Done.
// A one-cycle-latency memory model sits on the C port.
module tb_sad_best_match;
  localparam int CW    = 7;
  localparam int DEPTH = 128;
  localparam int SW    = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Go;
  logic [SW-1:0] Thresh;
  logic [CW-1:0] C_Addr;
  logic          C_RW;
  logic          C_En;
  logic [SW-1:0] C_Data;
  logic          Busy;
  logic          Done;
  logic [SW-1:0] Min_SAD;
  logic [CW-1:0] Min_Addr;
  logic [CW:0]   Match_Cnt;

  sad_best_match #(.C_WIDTH(CW), .DEPTH(DEPTH), .S_WIDTH(SW)) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Thresh(Thresh),
    .C_Addr(C_Addr), .C_RW(C_RW), .C_En(C_En), .C_Data(C_Data),
    .Busy(Busy), .Done(Done), .Min_SAD(Min_SAD), .Min_Addr(Min_Addr),
    .Match_Cnt(Match_Cnt)
  );

  always #5 Clk = ~Clk;

  logic [SW-1:0] mem [DEPTH];

  always @(posedge Clk) begin
    if (C_En) C_Data <= mem[C_Addr];
  end

  typedef struct {
    logic [SW-1:0] min_sad;
    logic [CW-1:0] min_addr;
    logic [CW:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Computes the expected result from the memory contents and pushes it.
  // Then sends a one-cycle Go; the edge that samples it is edge 0.
  // Thresh is corrupted afterwards to confirm the DUT captured it at Go.
  task automatic start_scan(input logic [SW-1:0] t);
    exp_t e;
    e.min_sad  = mem[0];
    e.min_addr = '0;
    e.cnt      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] < e.min_sad) begin
        e.min_sad  = mem[i];
        e.min_addr = CW'(i);
      end
      if (mem[i] < t) e.cnt = e.cnt + 1'b1;
    end
    sb.push_back(e);
    @(negedge Clk);
    Go = 1'b1;
    Thresh = t;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    Thresh = ~t;
  endtask

  // Follows the scan cycle by cycle from edge 0. Iteration n samples the cycle after edge n.
  // Optionally pulses Go at edges ga and gb.
  // Returns at the negedge of the Done cycle, or after a bounded number of cycles.
  task automatic wait_done(input int ga, input int gb, output int done_edge,
                           output int en_cnt, output int busy_bad, output int addr_bad);
    done_edge = -1;
    en_cnt    = 0;
    busy_bad  = 0;
    addr_bad  = 0;
    for (int n = 0; n <= 2*DEPTH + 20; n++) begin
      if (n > 0) @(posedge Clk);
      @(negedge Clk);
      if (C_En === 1'b1) begin
        if (C_Addr !== CW'(en_cnt)) addr_bad++;
        en_cnt++;
      end
      if (Busy !== (n < 2*DEPTH)) busy_bad++;
      Go = ((n + 1) == ga) || ((n + 1) == gb);
      if (Done === 1'b1) begin
        done_edge = n;
        break;
      end
    end
    Go = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    Go = 1'b0;
    Thresh = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_vec++; if (C_Addr !== '0) begin n_err++; $display("FAIL rst C_Addr got %0h want 0", C_Addr); end
    n_vec++; if (C_RW !== 1'b0) begin n_err++; $display("FAIL rst C_RW got %b want 0", C_RW); end
    n_vec++; if (C_En !== 1'b0) begin n_err++; $display("FAIL rst C_En got %b want 0", C_En); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst Busy got %b want 0", Busy); end
    n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL rst Done got %b want 0", Done); end
    n_vec++; if (Min_SAD !== '0) begin n_err++; $display("FAIL rst Min_SAD got %0h want 0", Min_SAD); end
    n_vec++; if (Min_Addr !== '0) begin n_err++; $display("FAIL rst Min_Addr got %0h want 0", Min_Addr); end
    n_vec++; if (Match_Cnt !== '0) begin n_err++; $display("FAIL rst Match_Cnt got %0h want 0", Match_Cnt); end
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    n_vec++; if ({C_En, Busy, Done} !== 3'b000) begin n_err++; $display("FAIL idle_no_go En/Busy/Done got %b want 000", {C_En, Busy, Done}); end
  endtask

  // Pattern 0: all entries equal. Pattern 1: descending values. Pattern 2: duplicate minima. Pattern 3: saturated data.
  task automatic test_patterns();
    int de, ec, bb, ab;
    exp_t e;
    logic [SW-1:0] t;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case (p)
          0: mem[i] = 32'd5;
          1: mem[i] = 32'(1000 - i);
          2: mem[i] = (i == 40 || i == 90) ? 32'd3 : 32'd50;
          default: mem[i] = 32'hFFFF_FFFF;
        endcase
      end
      case (p)
        0: t = 32'd6;
        1: t = 32'd900;
        2: t = 32'd4;
        default: t = 32'hFFFF_FFFF;
      endcase
      start_scan(t);
      wait_done(-1, -1, de, ec, bb, ab);
      e = sb.pop_front();
      n_vec++; if (de !== 2*DEPTH) begin n_err++; $display("FAIL pat%0d done_edge got %0d want %0d", p, de, 2*DEPTH); end
      n_vec++; if (ec !== DEPTH) begin n_err++; $display("FAIL pat%0d c_en_pulses got %0d want %0d", p, ec, DEPTH); end
      n_vec++; if (bb !== 0) begin n_err++; $display("FAIL pat%0d busy_profile got %0d bad cycles want 0", p, bb); end
      n_vec++; if (ab !== 0) begin n_err++; $display("FAIL pat%0d addr_order got %0d bad reads want 0", p, ab); end
      n_vec++; if (Min_SAD !== e.min_sad) begin n_err++; $display("FAIL pat%0d Min_SAD got %0h want %0h", p, Min_SAD, e.min_sad); end
      n_vec++; if (Min_Addr !== e.min_addr) begin n_err++; $display("FAIL pat%0d Min_Addr got %0d want %0d", p, Min_Addr, e.min_addr); end
      n_vec++; if (Match_Cnt !== e.cnt) begin n_err++; $display("FAIL pat%0d Match_Cnt got %0d want %0d", p, Match_Cnt, e.cnt); end
      repeat (3) @(negedge Clk);
      n_vec++; if (Done !== 1'b0) begin n_err++; $display("FAIL pat%0d done_one_cycle got %b want 0", p, Done); end
      n_vec++; if ({Min_SAD, Min_Addr, Match_Cnt} !== {e.min_sad, e.min_addr, e.cnt}) begin n_err++; $display("FAIL pat%0d hold got %0h/%0d/%0d want %0h/%0d/%0d", p, Min_SAD, Min_Addr, Match_Cnt, e.min_sad, e.min_addr, e.cnt); end
    end
  endtask

  task automatic test_go_while_busy();
    int de, ec, bb, ab, stray;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'($urandom_range(0, 1000));
    start_scan(32'd500);
    wait_done(10, 256, de, ec, bb, ab);
    e = sb.pop_front();
    n_vec++; if (de !== 2*DEPTH) begin n_err++; $display("FAIL gobusy done_edge got %0d want %0d", de, 2*DEPTH); end
    n_vec++; if (ec !== DEPTH) begin n_err++; $display("FAIL gobusy c_en_pulses got %0d want %0d", ec, DEPTH); end
    n_vec++; if (bb !== 0) begin n_err++; $display("FAIL gobusy busy_profile got %0d want 0", bb); end
    n_vec++; if ({Min_SAD, Min_Addr, Match_Cnt} !== {e.min_sad, e.min_addr, e.cnt}) begin n_err++; $display("FAIL gobusy result got %0h/%0d/%0d want %0h/%0d/%0d", Min_SAD, Min_Addr, Match_Cnt, e.min_sad, e.min_addr, e.cnt); end
    // A Go raised in the Done cycle must not start a new scan.
    Go = 1'b1;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge Clk);
      if (C_En || Busy || Done) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL go_in_done stray_activity got %0d want 0", stray); end
  endtask

  task automatic test_reset_mid_scan();
    int de, ec, bb, ab, dn, en;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    start_scan(32'h8000_0000);
    repeat (49) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    void'(sb.pop_back());
    n_vec++; if ({C_Addr, C_RW, C_En, Busy, Done} !== '0) begin n_err++; $display("FAIL midrst ctl got %0h want 0", {C_Addr, C_RW, C_En, Busy, Done}); end
    n_vec++; if ({Min_SAD, Min_Addr, Match_Cnt} !== '0) begin n_err++; $display("FAIL midrst results got %0h/%0d/%0d want 0/0/0", Min_SAD, Min_Addr, Match_Cnt); end
    dn = 0;
    en = 0;
    repeat (2*DEPTH + 10) begin
      @(negedge Clk);
      if (Done) dn++;
      if (C_En) en++;
    end
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL midrst stray_done got %0d want 0", dn); end
    n_vec++; if (en !== 0) begin n_err++; $display("FAIL midrst stray_c_en got %0d want 0", en); end
    start_scan(32'h8000_0000);
    wait_done(-1, -1, de, ec, bb, ab);
    e = sb.pop_front();
    n_vec++; if (de !== 2*DEPTH) begin n_err++; $display("FAIL postrst done_edge got %0d want %0d", de, 2*DEPTH); end
    n_vec++; if ({Min_SAD, Min_Addr, Match_Cnt} !== {e.min_sad, e.min_addr, e.cnt}) begin n_err++; $display("FAIL postrst result got %0h/%0d/%0d want %0h/%0d/%0d", Min_SAD, Min_Addr, Match_Cnt, e.min_sad, e.min_addr, e.cnt); end
  endtask

  // The second Go is raised in the first cycle after Done, the earliest restart the DUT accepts.
  task automatic test_back_to_back();
    int de, ec, bb, ab;
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'($urandom_range(0, 300));
      mem[$urandom_range(0, DEPTH-1)] = '0;
      start_scan(32'($urandom_range(50, 250)));
      wait_done(-1, -1, de, ec, bb, ab);
      e = sb.pop_front();
      n_vec++; if (de !== 2*DEPTH) begin n_err++; $display("FAIL b2b%0d done_edge got %0d want %0d", s, de, 2*DEPTH); end
      n_vec++; if (ab !== 0) begin n_err++; $display("FAIL b2b%0d addr_order got %0d want 0", s, ab); end
      n_vec++; if (Min_SAD !== e.min_sad) begin n_err++; $display("FAIL b2b%0d Min_SAD got %0h want %0h", s, Min_SAD, e.min_sad); end
      n_vec++; if (Min_Addr !== e.min_addr) begin n_err++; $display("FAIL b2b%0d Min_Addr got %0d want %0d", s, Min_Addr, e.min_addr); end
      n_vec++; if (Match_Cnt !== e.cnt) begin n_err++; $display("FAIL b2b%0d Match_Cnt got %0d want %0d", s, Match_Cnt, e.cnt); end
    end
  endtask

  initial begin
    Rst = 1'b1;
    Go = 1'b0;
    Thresh = '0;
    test_reset();
    test_patterns();
    test_go_while_busy();
    test_reset_mid_scan();
    test_back_to_back();
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
